// File: rtl/vce2_pkg.sv
// Shared types for the vce2 vector engine blocks.
package vce2_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WAIT_AGU,
        ST_RD_RS1,
        ST_WAIT_RS1,
        ST_RD_RS2,
        ST_WAIT_RS2,
        ST_EXEC,
        ST_WR_RD,
        ST_WAIT_WR,
        ST_DONE
    } vrf_seq_state_e;

    localparam logic [3:0] BE_ALL = 4'hF;

endpackage

// File: rtl/vce2_vrf_seq.sv
// Element sequencer: per element reads rs1 and rs2, hands them to the ALU,
// then writes the result back to rd, steering the AGU selects along the way.
module vce2_vrf_seq
    import vce2_pkg::*;
#(
    parameter int unsigned VlWidth   = 8,
    parameter int unsigned DataWidth = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic [VlWidth-1:0]   vl_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 agu_load_o,
    input  logic                 agu_ready_i,
    output logic                 agu_get_rs1_o,
    output logic                 agu_get_rs2_o,
    output logic                 agu_get_rd_o,
    output logic                 agu_incr_o,
    output logic                 data_req_o,
    input  logic                 data_gnt_i,
    input  logic                 data_rvalid_i,
    output logic                 data_we_o,
    output logic [3:0]           data_be_o,
    output logic [DataWidth-1:0] data_wdata_o,
    input  logic [DataWidth-1:0] data_rdata_i,
    output logic                 op_valid_o,
    output logic [DataWidth-1:0] op_a_o,
    output logic [DataWidth-1:0] op_b_o,
    input  logic                 result_valid_i,
    input  logic [DataWidth-1:0] result_i
);

    localparam logic [VlWidth-1:0] VlOne = 1;

    vrf_seq_state_e     state, state_nxt;
    logic [VlWidth-1:0] cnt, vl;
    logic [DataWidth-1:0] op_a, op_b, res;
    logic               last_elem;

    // Only reached with vl != 0, so vl - 1 never underflows here.
    assign last_elem = (cnt == (vl - VlOne));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        busy_o        = 1'b1;
        done_o        = 1'b0;
        agu_load_o    = 1'b0;
        agu_get_rs1_o = 1'b0;
        agu_get_rs2_o = 1'b0;
        agu_get_rd_o  = 1'b0;
        data_req_o    = 1'b0;
        data_we_o     = 1'b0;
        op_valid_o    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                busy_o = 1'b0;
                if (start_i) state_nxt = (vl_i == '0) ? ST_DONE : ST_LOAD;
            end
            ST_LOAD: begin
                agu_load_o = 1'b1;
                state_nxt  = ST_WAIT_AGU;
            end
            ST_WAIT_AGU: if (agu_ready_i) state_nxt = ST_RD_RS1;
            ST_RD_RS1: begin
                agu_get_rs1_o = 1'b1;
                data_req_o    = 1'b1;
                if (data_gnt_i) state_nxt = ST_WAIT_RS1;
            end
            ST_WAIT_RS1: begin
                agu_get_rs1_o = 1'b1;
                if (data_rvalid_i) state_nxt = ST_RD_RS2;
            end
            ST_RD_RS2: begin
                agu_get_rs2_o = 1'b1;
                data_req_o    = 1'b1;
                if (data_gnt_i) state_nxt = ST_WAIT_RS2;
            end
            ST_WAIT_RS2: begin
                agu_get_rs2_o = 1'b1;
                if (data_rvalid_i) state_nxt = ST_EXEC;
            end
            ST_EXEC: begin
                op_valid_o = 1'b1;
                if (result_valid_i) state_nxt = ST_WR_RD;
            end
            ST_WR_RD: begin
                agu_get_rd_o = 1'b1;
                data_req_o   = 1'b1;
                data_we_o    = 1'b1;
                if (data_gnt_i) state_nxt = ST_WAIT_WR;
            end
            ST_WAIT_WR: begin
                agu_get_rd_o = 1'b1;
                if (data_rvalid_i) state_nxt = last_elem ? ST_DONE : ST_RD_RS1;
            end
            ST_DONE: begin
                done_o    = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt  <= '0;
            vl   <= '0;
            op_a <= '0;
            op_b <= '0;
            res  <= '0;
        end else begin
            if (state == ST_IDLE && start_i) begin
                cnt <= '0;
                vl  <= vl_i;
            end
            if (state == ST_WAIT_RS1 && data_rvalid_i) op_a <= data_rdata_i;
            if (state == ST_WAIT_RS2 && data_rvalid_i) op_b <= data_rdata_i;
            if (state == ST_EXEC && result_valid_i)    res  <= result_i;
            if (state == ST_WAIT_WR && data_rvalid_i && !last_elem) cnt <= cnt + VlOne;
        end
    end

    assign agu_incr_o   = data_req_o & data_gnt_i;
    assign data_be_o    = BE_ALL;
    assign data_wdata_o = res;
    assign op_a_o       = op_a;
    assign op_b_o       = op_b;

endmodule
